// File: rtl/axis_pkt_sequencer_pkg.sv
// Shared types and constants for the packet sequencer.
package axis_pkt_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_e;
  localparam int MIN_PKT_SIZE = 2;
endpackage

// File: rtl/axis_pkt_sequencer_if.sv
// AXI-Stream bundle between the sequencer and the downstream data FIFO.
interface axis_pkt_sequencer_if #(parameter int DW = 64);
  logic [DW-1:0]   tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;
  logic [DW/8-1:0] tkeep;

  modport master (output tdata, tvalid, tlast, tkeep, input tready);
  modport slave  (input tdata, tvalid, tlast, tkeep, output tready);
endinterface

// File: rtl/axis_pkt_sequencer_out_reg.sv
// Single-entry AXIS output register: load when empty or draining, hold while stalled.
module axis_out_reg #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic          tready,
  output logic          tvalid,
  output logic [DW-1:0] tdata,
  output logic          tlast
);
  // Caller only asserts load when (!tvalid | tready), so a load never overwrites a stalled beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= ld_data;
      tlast  <= ld_last;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end
endmodule

// File: rtl/axis_pkt_sequencer.sv
// Capture sequencer: arm/trigger/run/drain FSM, TLAST framing, packet limit and drop accounting.
module axis_pkt_sequencer
  import axis_pkt_pkg::*;
#(
  parameter int DW = 64,
  parameter int CW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start_i,
  input  logic                 cfg_abort_i,
  input  logic                 cfg_trig_en_i,
  input  logic [CW-1:0]        cfg_pkt_size_i,
  input  logic [CW-1:0]        cfg_num_pkt_i,
  input  logic                 trig_i,
  input  logic [DW-1:0]        src_data_i,
  input  logic                 src_valid_i,
  axis_pkt_sequencer_if.master m_axis,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cfg_err_o,
  output logic                 overflow_o,
  output logic [CW-1:0]        pkt_cnt_o,
  output logic [CW-1:0]        drop_cnt_o
);
  state_e        state_q, state_d;
  logic [CW-1:0] beat_cnt, pkt_size_q, num_pkt_q, pkt_cnt_q, drop_cnt_q;
  logic          ovf_q, err_q, done_q, done_d;
  logic          tvalid, tlast;
  logic [DW-1:0] tdata;
  logic          hs, last_hs, room, last_beat, final_pkt, cap_en, accept, drop, start_ok;

  assign hs        = tvalid & m_axis.tready;
  assign last_hs   = hs & tlast;
  assign room      = ~tvalid | m_axis.tready;
  assign last_beat = (beat_cnt == pkt_size_q - CW'(1));
  assign final_pkt = (num_pkt_q != '0) && (pkt_cnt_q + CW'(1) == num_pkt_q);
  assign start_ok  = cfg_start_i && (cfg_pkt_size_i >= CW'(MIN_PKT_SIZE));
  assign drop      = ((state_q == RUN) || (state_q == DRAIN)) & src_valid_i & tvalid & ~m_axis.tready;
  assign accept    = cap_en & src_valid_i & room;

  // Once a TLAST beat that ends the capture sits in the out reg, stop loading new samples.
  always_comb begin
    cap_en = 1'b0;
    case (state_q)
      ARMED:   cap_en = trig_i & ~cfg_abort_i;
      RUN:     cap_en = ~(tvalid & tlast & final_pkt);
      DRAIN:   cap_en = ~(tvalid & tlast);
      default: cap_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start_ok) state_d = cfg_trig_en_i ? ARMED : RUN;
      ARMED: begin
        if (cfg_abort_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (trig_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_hs && final_pkt) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cfg_abort_i) begin
          // Stop at once only on a packet boundary with the out reg emptying this cycle.
          if ((beat_cnt == '0) && room && !accept) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      beat_cnt   <= '0;
      pkt_size_q <= '0;
      num_pkt_q  <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == IDLE && cfg_start_i) begin
        if (start_ok) begin
          pkt_size_q <= cfg_pkt_size_i;
          num_pkt_q  <= cfg_num_pkt_i;
          pkt_cnt_q  <= '0;
          drop_cnt_q <= '0;
          ovf_q      <= 1'b0;
          beat_cnt   <= '0;
          err_q      <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end else begin
        if (accept)  beat_cnt  <= last_beat ? '0 : beat_cnt + CW'(1);
        if (last_hs) pkt_cnt_q <= pkt_cnt_q + CW'(1);
        if (drop) begin
          ovf_q <= 1'b1;
          if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CW'(1);
        end
      end
    end
  end

  axis_out_reg #(.DW(DW)) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .ld_data (src_data_i),
    .ld_last (last_beat),
    .tready  (m_axis.tready),
    .tvalid  (tvalid),
    .tdata   (tdata),
    .tlast   (tlast)
  );

  assign m_axis.tvalid = tvalid;
  assign m_axis.tdata  = tdata;
  assign m_axis.tlast  = tlast;
  assign m_axis.tkeep  = '1;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign cfg_err_o     = err_q;
  assign overflow_o    = ovf_q;
  assign pkt_cnt_o     = pkt_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;
endmodule

// File: tb/tb_axis_pkt_sequencer.sv
// Bench for axis_pkt_sequencer: count-based capture model checked every cycle plus directed literals.
module tb_axis_pkt_sequencer;
  localparam int DW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, abort = 1'b0, trig_en = 1'b0, trig = 1'b0;
  logic [CW-1:0] size = 4, num = 1;
  logic [DW-1:0] sdata = '0;
  logic          svalid = 1'b0, tready = 1'b1;
  logic          busy, done, err, ovf;
  logic [CW-1:0] pkt_cnt, drop_cnt;

  axis_pkt_sequencer_if #(.DW(DW)) m_axis ();
  assign m_axis.tready = tready;

  axis_pkt_sequencer #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .cfg_start_i(start), .cfg_abort_i(abort), .cfg_trig_en_i(trig_en),
    .cfg_pkt_size_i(size), .cfg_num_pkt_i(num), .trig_i(trig), .src_data_i(sdata), .src_valid_i(svalid),
    .m_axis(m_axis), .busy_o(busy), .done_o(done), .cfg_err_o(err), .overflow_o(ovf),
    .pkt_cnt_o(pkt_cnt), .drop_cnt_o(drop_cnt));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;

  // Model: a capture is a run of taken samples; tlast follows from the running count, the
  // limit is num*size beats, and an abort rounds the limit up to the next packet boundary.
  beat_t       oq[$];
  int          m_mode;      // 0 idle, 1 waiting for trigger, 2 capturing, 3 stopping
  longint      taken, delivered, stop_at, lim;
  int unsigned m_size, m_num, m_pkt, m_drop;
  bit          m_ovf, m_err, m_done, m_hs, m_cap, m_take;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      oq.delete(); m_mode = 0; taken = 0; delivered = 0; stop_at = 0;
      m_pkt = 0; m_drop = 0; m_ovf = 1'b0; m_err = 1'b0;
    end else begin
      m_hs  = (oq.size() != 0) && tready;
      m_cap = (m_mode >= 2) || (m_mode == 1 && trig && !abort);
      lim   = (m_mode == 3) ? stop_at :
              (m_num == 0) ? 64'sh3fff_ffff_ffff_ffff : longint'(m_num) * longint'(m_size);
      m_take = m_cap && svalid && (oq.size() == 0 || m_hs) && taken < lim;
      if (m_mode >= 2 && svalid && oq.size() != 0 && !tready) begin
        if (m_drop != 32'hffff_ffff) m_drop++;
        m_ovf = 1'b1;
      end
      if (m_hs) begin
        if (oq[0].l) m_pkt++;
        void'(oq.pop_front());
        delivered++;
      end
      if (m_take) begin
        oq.push_back('{sdata, (taken % longint'(m_size)) == longint'(m_size) - 1});
        taken++;
      end
      case (m_mode)
        0: if (start) begin
          if (size < 2) m_err = 1'b1;
          else begin
            m_size = size; m_num = num; m_pkt = 0; m_drop = 0; m_ovf = 1'b0; m_err = 1'b0;
            taken = 0; delivered = 0; m_mode = trig_en ? 1 : 2;
          end
        end
        1: if (abort) begin m_mode = 0; m_done = 1'b1; end
           else if (trig) m_mode = 2;
        2: if (m_num != 0 && delivered == longint'(m_num) * longint'(m_size)) begin
             m_mode = 0; m_done = 1'b1;
           end else if (abort) begin
             stop_at = ((taken + longint'(m_size) - 1) / longint'(m_size)) * longint'(m_size);
             if (delivered == stop_at) begin m_mode = 0; m_done = 1'b1; end
             else m_mode = 3;
           end
        default: if (delivered == stop_at) begin m_mode = 0; m_done = 1'b1; end
      endcase
    end
  end

  // Per-cycle comparison plus a log of delivered beats and done pulses.
  bit    chk_en = 1'b0;
  beat_t blog[$];
  int    done_cnt = 0;
  logic  e_v, e_l, a_l;
  logic [DW-1:0] e_d, a_d;

  always @(negedge clk) begin
    if (chk_en) begin
      e_v = oq.size() != 0;
      e_d = e_v ? oq[0].d : '0;
      e_l = e_v ? oq[0].l : 1'b0;
      a_d = m_axis.tvalid ? m_axis.tdata : '0;
      a_l = m_axis.tvalid ? m_axis.tlast : 1'b0;
      n_tests++;
      if (m_axis.tvalid !== e_v || a_d !== e_d || a_l !== e_l || busy !== (m_mode != 0) ||
          done !== m_done || err !== m_err || ovf !== m_ovf || pkt_cnt !== m_pkt || drop_cnt !== m_drop) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got v=%0b d=%0h l=%0b busy=%0b done=%0b err=%0b ovf=%0b pkt=%0d drop=%0d want v=%0b d=%0h l=%0b busy=%0b done=%0b err=%0b ovf=%0b pkt=%0d drop=%0d",
                 $time, m_axis.tvalid, a_d, a_l, busy, done, err, ovf, pkt_cnt, drop_cnt,
                 e_v, e_d, e_l, m_mode != 0, m_done, m_err, m_ovf, m_pkt, m_drop);
      end
      if (m_axis.tvalid && tready) blog.push_back('{m_axis.tdata, m_axis.tlast});
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic begin_run(input logic te, input logic [CW-1:0] sz, input logic [CW-1:0] n);
    blog.delete(); done_cnt = 0;
    trig_en = te; size = sz; num = n; start = 1'b1; sdata = 64'hdead;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int n, input int abort_at);
    for (int i = 0; i < n; i++) begin
      sdata = DW'(i); abort = (i == abort_at);
      tick();
    end
    abort = 1'b0;
  endtask

  initial begin
    svalid = 1'b1;
    tick(); tick();
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnts", {pkt_cnt, drop_cnt}, 0);
    chk("tkeep", m_axis.tkeep, 8'hff);
    chk_en = 1'b1;
    reset = 1'b0;
    tick();

    // Free-run, two packets of four.
    begin_run(1'b0, 4, 2);
    stream(12, -1);
    chk("t1_beats", blog.size(), 8);
    for (int i = 0; i < 8 && i < blog.size(); i++) begin
      chk("t1_data", blog[i].d, i);
      chk("t1_last", blog[i].l, (i == 3 || i == 7));
    end
    chk("t1_pkt", pkt_cnt, 2);
    chk("t1_done", done_cnt, 1);
    chk("t1_busy", busy, 0);

    // Triggered capture: first beat is the trigger-cycle sample.
    begin_run(1'b1, 4, 1);
    for (int c = 1; c < 10; c++) begin sdata = DW'(c + 256); tick(); end
    chk("t2_pre_trig", blog.size(), 0);
    trig = 1'b1; sdata = 64'ha0; tick(); trig = 1'b0;
    stream(8, -1);
    chk("t2_beats", blog.size(), 4);
    if (blog.size() > 0) chk("t2_first", blog[0].d, 64'ha0);
    chk("t2_done", done_cnt, 1);
    // Abort while armed.
    begin_run(1'b1, 4, 1);
    tick(); tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    tick(); tick();
    chk("t2_abort_beats", blog.size(), 0);
    chk("t2_abort_done", done_cnt, 1);
    chk("t2_abort_busy", busy, 0);

    // Back-pressure mid-packet: three dropped samples, packet still four beats.
    begin_run(1'b0, 4, 1);
    for (int i = 0; i < 10; i++) begin
      sdata = DW'(i); tready = !(i >= 2 && i <= 4);
      tick();
    end
    tready = 1'b1;
    chk("t3_drop", drop_cnt, 3);
    chk("t3_ovf", ovf, 1);
    chk("t3_beats", blog.size(), 4);
    if (blog.size() == 4) begin
      chk("t3_d", {blog[0].d[7:0], blog[1].d[7:0], blog[2].d[7:0], blog[3].d[7:0]}, 32'h00010506);
      chk("t3_l", {blog[0].l, blog[1].l, blog[2].l, blog[3].l}, 4'b0001);
    end

    // Continuous mode, abort after beat 5: packet completes at beat 7.
    begin_run(1'b0, 4, 0);
    stream(12, 6);
    chk("t4_beats", blog.size(), 8);
    if (blog.size() == 8) chk("t4_last7", {blog[7].d[7:0], blog[7].l}, {8'd7, 1'b1});
    chk("t4_pkt", pkt_cnt, 2);
    chk("t4_done", done_cnt, 1);

    // Illegal size, then a legal start issued together with abort.
    begin_run(1'b0, 1, 1);
    chk("t5_err", err, 1);
    chk("t5_busy", busy, 0);
    abort = 1'b1;
    begin_run(1'b0, 2, 2);
    abort = 1'b0;
    chk("t5_err_clr", err, 0);
    stream(8, -1);
    chk("t5_beats", blog.size(), 4);
    if (blog.size() == 4) chk("t5_l", {blog[0].l, blog[1].l, blog[2].l, blog[3].l}, 4'b0101);

    // Reset mid-packet, then restart framing from beat 0.
    begin_run(1'b0, 4, 0);
    stream(3, -1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_tvalid", m_axis.tvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cnts", {pkt_cnt, drop_cnt}, 0);
    begin_run(1'b0, 4, 1);
    stream(8, -1);
    chk("t6_beats", blog.size(), 4);
    if (blog.size() == 4) chk("t6_frame", {blog[0].d[7:0], blog[3].l, blog[2].l}, {8'd0, 1'b1, 1'b0});

    // Abort coincident with the final tlast handshake: one done pulse.
    begin_run(1'b0, 2, 1);
    stream(6, 2);
    chk("t7_beats", blog.size(), 2);
    chk("t7_done", done_cnt, 1);
    chk("t7_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
